// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Cuts the codec sample stream into FFT_LEN-sample blocks for a streaming FFT core.
//   After each block it waits for the core's result eop. It then discards HOLDOFF
//   audio samples before starting the next block, which decimates the spectrum
//   refresh rate.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   enable            1 = start new blocks; 0 = finish the current block, then idle
//   audio_data/valid  PCM sample and its 1-cycle strobe from the codec receiver
//   fft_ready         FFT sink ready
//   fft_src_valid/eop FFT result stream valid / end of result block
//   fft_sink_*        registered sample stream into the FFT core
//   busy              block in flight (FILL or WAIT)
//   frame_done        1-cycle pulse after the result eop is seen
//   timeout_err       sticky, set when the result eop never arrives
//   drop_cnt          saturating count of samples lost inside a block
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no block open; an enabled accepted sample starts one (sop)
// S_FILL | sending the rest of the block; a stall drops the sample
// S_WAIT | block sent; waiting for the result eop or a timeout
// S_HOLD | hold-off; counting discarded audio samples
module fft_frame_sequencer #(
  parameter int FFT_LEN = 128,
  parameter int HOLDOFF = 256,
  parameter int TIMEOUT = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] audio_data,
  input  logic        audio_valid,
  input  logic        fft_ready,
  input  logic        fft_src_valid,
  input  logic        fft_src_eop,
  output logic        fft_sink_valid,
  output logic        fft_sink_sop,
  output logic        fft_sink_eop,
  output logic [15:0] fft_sink_data,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [15:0] drop_cnt
);

  localparam int IDX_W  = $clog2(FFT_LEN);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_HOLD} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [HOLD_W-1:0]  hold, hold_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic               valid_next, sop_next, eop_next;
  logic [15:0]        data_next;
  logic               frame_done_next, timeout_next;
  logic [15:0]        drop_next;
  logic               accept;

  assign accept = audio_valid & fft_ready;
  assign busy   = (state == S_FILL) | (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      hold           <= '0;
      timer          <= '0;
      fft_sink_valid <= 1'b0;
      fft_sink_sop   <= 1'b0;
      fft_sink_eop   <= 1'b0;
      fft_sink_data  <= '0;
      frame_done     <= 1'b0;
      timeout_err    <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      hold           <= hold_next;
      timer          <= timer_next;
      fft_sink_valid <= valid_next;
      fft_sink_sop   <= sop_next;
      fft_sink_eop   <= eop_next;
      fft_sink_data  <= data_next;
      frame_done     <= frame_done_next;
      timeout_err    <= timeout_next;
      drop_cnt       <= drop_next;
    end
  end

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    hold_next       = hold;
    timer_next      = timer;
    valid_next      = 1'b0;
    sop_next        = 1'b0;
    eop_next        = 1'b0;
    data_next       = fft_sink_data;
    frame_done_next = 1'b0;
    timeout_next    = timeout_err;
    drop_next       = drop_cnt;

    case (state)
      S_IDLE: begin
        if (enable && accept) begin
          valid_next = 1'b1;
          sop_next   = 1'b1;
          data_next  = audio_data;
          idx_next   = IDX_W'(1);
          state_next = S_FILL;
        end
      end

      S_FILL: begin
        // enable is ignored here: a truncated block would corrupt the FFT core.
        if (accept) begin
          valid_next = 1'b1;
          data_next  = audio_data;
          if (idx == IDX_W'(FFT_LEN - 1)) begin
            eop_next   = 1'b1;
            idx_next   = '0;
            // Down-counter holds the WAIT cycles left; terminal count 0 means
            // this is the TIMEOUT-th WAIT cycle.
            timer_next = TMR_W'(TIMEOUT - 1);
            state_next = S_WAIT;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end else if (audio_valid && (drop_cnt != 16'hFFFF)) begin
          drop_next = drop_cnt + 16'd1;
        end
      end

      S_WAIT: begin
        // The result eop takes priority over a timeout in the same cycle.
        if (fft_src_valid && fft_src_eop) begin
          frame_done_next = 1'b1;
          if (HOLDOFF == 0) begin
            state_next = S_IDLE;
          end else begin
            hold_next  = HOLD_W'(HOLDOFF);
            state_next = S_HOLD;
          end
        end else if (timer == '0) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end else begin
          timer_next = timer - TMR_W'(1);
        end
      end

      S_HOLD: begin
        if (audio_valid) begin
          hold_next = hold - HOLD_W'(1);
          if (hold == HOLD_W'(1)) state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
//   Directed bench for fft_frame_sequencer with FFT_LEN=8 and TIMEOUT=16.
//   dut_a uses HOLDOFF=0 and dut_b uses HOLDOFF=3. Both see the same stimulus.
module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        fft_ready;
  logic        fft_src_valid;
  logic        fft_src_eop;

  logic        a_valid, a_sop, a_eop, a_busy, a_done, a_terr;
  logic [15:0] a_data, a_drop;
  logic        b_valid, b_sop, b_eop, b_busy, b_done, b_terr;
  logic [15:0] b_data, b_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.FFT_LEN(8), .HOLDOFF(0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .audio_data(audio_data),
    .audio_valid(audio_valid), .fft_ready(fft_ready),
    .fft_src_valid(fft_src_valid), .fft_src_eop(fft_src_eop),
    .fft_sink_valid(a_valid), .fft_sink_sop(a_sop), .fft_sink_eop(a_eop),
    .fft_sink_data(a_data), .busy(a_busy), .frame_done(a_done),
    .timeout_err(a_terr), .drop_cnt(a_drop)
  );

  fft_frame_sequencer #(.FFT_LEN(8), .HOLDOFF(3), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .audio_data(audio_data),
    .audio_valid(audio_valid), .fft_ready(fft_ready),
    .fft_src_valid(fft_src_valid), .fft_src_eop(fft_src_eop),
    .fft_sink_valid(b_valid), .fft_sink_sop(b_sop), .fft_sink_eop(b_eop),
    .fft_sink_data(b_data), .busy(b_busy), .frame_done(b_done),
    .timeout_err(b_terr), .drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic rdy);
    audio_data  = d;
    audio_valid = 1'b1;
    fft_ready   = rdy;
    @(posedge clk);
    #1;
    audio_valid = 1'b0;
    fft_ready   = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; audio_data = '0; audio_valid = 1'b0;
    fft_ready = 1'b1; fft_src_valid = 1'b0; fft_src_eop = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_sop",   32'(a_sop),   32'd0);
    chk("rst_eop",   32'(a_eop),   32'd0);
    chk("rst_data",  32'(a_data),  32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_terr",  32'(a_terr),  32'd0);
    chk("rst_drop",  32'(a_drop),  32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // T1: one full block of 1..8
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 1'b1);
      chk("t1_valid", 32'(a_valid), 32'd1);
      chk("t1_data",  32'(a_data),  32'(i));
      chk("t1_sop",   32'(a_sop),   32'(i == 1));
      chk("t1_eop",   32'(a_eop),   32'(i == 8));
      chk("t1_busy",  32'(a_busy),  32'd1);
      chk("t1_b_eop", 32'(b_eop),   32'(i == 8));
      tick();
      chk("t1_valid_gap", 32'(a_valid), 32'd0);
    end

    // T2: strobes in WAIT are discarded
    for (int i = 0; i < 5; i++) begin
      send(16'(100 + i), 1'b1);
      chk("t2_wait_valid",   32'(a_valid), 32'd0);
      chk("t2_wait_b_valid", 32'(b_valid), 32'd0);
      tick();
    end
    repeat (4) tick();
    chk("t2_pre_terr", 32'(a_terr), 32'd0);
    chk("t2_pre_busy", 32'(a_busy), 32'd1);
    // result eop lands on the terminal WAIT cycle: eop must win
    fft_src_valid = 1'b1; fft_src_eop = 1'b1;
    tick();
    fft_src_valid = 1'b0; fft_src_eop = 1'b0;
    chk("t2_done",     32'(a_done), 32'd1);
    chk("t2_terr",     32'(a_terr), 32'd0);
    chk("t2_b_done",   32'(b_done), 32'd1);
    chk("t2_b_terr",   32'(b_terr), 32'd0);
    chk("t2_busy",     32'(a_busy), 32'd0);
    tick();
    chk("t2_done_pulse", 32'(a_done), 32'd0);
    send(16'd9, 1'b1);
    chk("t2_sop",   32'(a_sop),   32'd1);
    chk("t2_data",  32'(a_data),  32'd9);
    chk("t2_valid", 32'(a_valid), 32'd1);

    // T3: dut_b discards three strobes, the fourth starts a block
    chk("t3_b_hold1", 32'(b_valid), 32'd0);
    send(16'd10, 1'b1);
    chk("t3_b_hold2", 32'(b_valid), 32'd0);
    send(16'd11, 1'b1);
    chk("t3_b_hold3", 32'(b_valid), 32'd0);
    chk("t3_b_busy",  32'(b_busy),  32'd0);
    send(16'd12, 1'b1);
    chk("t3_b_sop",   32'(b_sop),   32'd1);
    chk("t3_b_data",  32'(b_data),  32'd12);
    chk("t3_b_busy2", 32'(b_busy),  32'd1);
    chk("t3_a_sop",   32'(a_sop),   32'd0);
    chk("t3_a_data",  32'(a_data),  32'd12);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // T4: stall on strobes 3 and 4, block still ends after 8 accepted samples
    for (int k = 0; k < 10; k++) begin
      logic rdy;
      rdy = !(k == 2 || k == 3);
      send(16'(20 + k), rdy);
      if (rdy) begin
        chk("t4_valid", 32'(a_valid), 32'd1);
        chk("t4_data",  32'(a_data),  32'(20 + k));
        chk("t4_sop",   32'(a_sop),   32'(k == 0));
        chk("t4_eop",   32'(a_eop),   32'(k == 9));
      end else begin
        chk("t4_drop_valid", 32'(a_valid), 32'd0);
        chk("t4_drop_hold",  32'(a_data),  32'd21);
      end
      tick();
    end
    chk("t4_drop_cnt",   32'(a_drop), 32'd2);
    chk("t4_b_drop_cnt", 32'(b_drop), 32'd2);

    // T5: no result eop -> timeout on the 16th WAIT cycle
    repeat (14) tick();
    chk("t5_pre_terr", 32'(a_terr), 32'd0);
    chk("t5_pre_busy", 32'(a_busy), 32'd1);
    tick();
    chk("t5_terr",   32'(a_terr), 32'd1);
    chk("t5_busy",   32'(a_busy), 32'd0);
    chk("t5_done",   32'(a_done), 32'd0);
    chk("t5_b_terr", 32'(b_terr), 32'd1);
    repeat (3) tick();
    chk("t5_sticky", 32'(a_terr), 32'd1);
    chk("t5_done2",  32'(a_done), 32'd0);

    // T6: enable drops mid-block, then reset mid-block
    for (int k = 0; k < 4; k++) begin
      send(16'(40 + k), 1'b1);
      chk("t6_valid", 32'(a_valid), 32'd1);
      chk("t6_sop",   32'(a_sop),   32'(k == 0));
    end
    enable = 1'b0;
    send(16'd44, 1'b1);
    chk("t6_noabort_valid", 32'(a_valid), 32'd1);
    chk("t6_noabort_data",  32'(a_data),  32'd44);
    chk("t6_noabort_busy",  32'(a_busy),  32'd1);
    rst = 1'b1;
    send(16'd45, 1'b1);
    rst = 1'b0;
    chk("t6_rst_valid", 32'(a_valid), 32'd0);
    chk("t6_rst_eop",   32'(a_eop),   32'd0);
    chk("t6_rst_data",  32'(a_data),  32'd0);
    chk("t6_rst_busy",  32'(a_busy),  32'd0);
    chk("t6_rst_terr",  32'(a_terr),  32'd0);
    chk("t6_rst_drop",  32'(a_drop),  32'd0);
    send(16'd46, 1'b1);
    chk("t6_idle_valid", 32'(a_valid), 32'd0);
    chk("t6_idle_sop",   32'(a_sop),   32'd0);
    chk("t6_idle_busy",  32'(a_busy),  32'd0);
    send(16'd47, 1'b0);
    chk("t6_idle_nodrop", 32'(a_drop), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
